// File: rtl/uart_pkg.sv
// Shared constants for the CPU-side UART RX FIFO front end.
package uart_pkg;

  // Master port state, one-hot.
  typedef enum logic [3:0] {
    M_IDLE = 4'b0001,
    M_RD   = 4'b0010,
    M_WR   = 4'b0100,
    M_GAP  = 4'b1000
  } mstate_e;

  localparam int unsigned FIFO_AW    = 4;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

  // Status word bit positions; count occupies [FIFO_AW:0].
  localparam int unsigned STAT_BUSY_BIT = 6;
  localparam int unsigned STAT_OVF_BIT  = 5;

endpackage

// File: rtl/sync_fifo8.sv
// 16x8 register FIFO. The caller gates push/pop against full/empty; a push while
// full is legal only together with a pop.
module sync_fifo8
  import uart_pkg::*;
(
  input  logic             clk_48_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [FIFO_AW:0] count_o
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clk_48_i) begin
    if (push_i) mem[wr_ptr] <= din_i;
  end

  // Pointers wrap naturally at 16; count tracks occupancy 0..16.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout_o  = mem[rd_ptr];
  assign count_o = count;
  assign full_o  = (count == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign empty_o = (count == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// Wishbone front end for uart1: drains RX bytes into a FIFO on the UART's
// interrupt and forwards CPU TX writes, spaced by a guard timer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter logic [31:0] DATA_ADR = 32'h100,
  parameter logic [31:0] STAT_ADR = 32'h101,
  parameter logic [31:0] UART_ADR = 32'h0FF,
  parameter logic [14:0] TX_GUARD = 15'd27500
) (
  input  logic        clk_48_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        uart_irq_i,
  output logic        irq_o
);

  mstate_e          state;
  logic             pending;
  logic [7:0]       tx_byte;
  logic [14:0]      guard;
  logic             overflow;

  logic             bus, hit_data, hit_stat;
  logic             rd_data, wr_data, rd_stat, wr_stat;
  logic             rx_req, wr_done, latch, tx_busy;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic [31:0]      stat_word;
  logic             unused_bits;

  assign unused_bits = ^{sel_i, dat_i[31:8], m_dat_i[31:8]};

  // CPU address decode and derived events.
  always_comb begin
    bus      = stb_i & cyc_i;
    hit_data = bus & (adr_i == DATA_ADR);
    hit_stat = bus & (adr_i == STAT_ADR);
    rd_data  = hit_data & ~we_i;
    wr_data  = hit_data & we_i;
    rd_stat  = hit_stat & ~we_i;
    wr_stat  = hit_stat & we_i;
    rx_req   = (state == M_RD) & m_ack_i;
    wr_done  = (state == M_WR) & m_ack_i;
    // ack_o low marks the first cycle of a strobe, so side effects fire once.
    latch    = wr_data & ~pending & ~ack_o;
    fifo_pop = rd_data & ~ack_o & ~fifo_empty;
    // A coincident pop frees the slot, so a full FIFO still accepts the byte.
    fifo_push = rx_req & (~fifo_full | fifo_pop);
    tx_busy   = pending | (guard != '0);
    stat_word = {25'b0, tx_busy, overflow, fifo_count};
  end

  sync_fifo8 u_fifo (
    .clk_48_i (clk_48_i),
    .rst_i    (rst_i),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .din_i    (m_dat_i[7:0]),
    .dout_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Master FSM with registered strobes, TX latch/pending and guard timer.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= M_IDLE;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_dat_o <= '0;
      pending <= 1'b0;
      tx_byte <= '0;
      guard   <= '0;
    end else begin
      if (guard != '0) guard <= guard - 15'd1;
      if (latch) begin
        tx_byte <= dat_i[7:0];
        pending <= 1'b1;
      end
      unique case (state)
        M_IDLE: begin
          if (uart_irq_i) begin
            state   <= M_RD;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b0;
          end else if (pending && guard == '0) begin
            state   <= M_WR;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b1;
            m_dat_o <= {24'b0, tx_byte};
          end
        end
        M_RD: begin
          if (m_ack_i) begin
            state   <= M_GAP;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
          end
        end
        M_WR: begin
          if (m_ack_i) begin
            state   <= M_GAP;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            guard   <= TX_GUARD;
            pending <= 1'b0;
          end
        end
        M_GAP:   state <= M_IDLE;
        default: state <= M_IDLE;
      endcase
    end
  end

  // CPU slave side: registered ack/data, overflow flag and irq.
  always_ff @(posedge clk_48_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      overflow <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      ack_o <= rd_data | rd_stat | wr_stat | (wr_data & wr_done);
      if (rd_data && !ack_o) begin
        dat_o <= fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_head};
      end else if (rd_stat && !ack_o) begin
        dat_o <= stat_word;
      end else if (!(rd_data || rd_stat)) begin
        dat_o <= '0;
      end
      if (rx_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end else if (rd_stat && !ack_o) begin
        overflow <= 1'b0;
      end
      irq_o <= ~fifo_empty;
    end
  end

  assign m_adr_o = UART_ADR;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo with a queue-based reference model
// and a simple UART slave model on the master port.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam logic [31:0] DATA_ADR = 32'h100;
  localparam logic [31:0] STAT_ADR = 32'h101;
  localparam logic [31:0] UART_ADR = 32'h0FF;
  localparam int          TX_GUARD = 27500;

  logic        clk, rst;
  logic [31:0] adr, wdat;
  logic        we, stb, cyc;
  logic [3:0]  sel;
  logic [31:0] dat_o, m_adr_o, m_dat_o, m_dat;
  logic        ack_o, m_we_o, m_stb_o, m_cyc_o, m_ack, uirq, irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .DATA_ADR (DATA_ADR),
    .STAT_ADR (STAT_ADR),
    .UART_ADR (UART_ADR),
    .TX_GUARD (15'(TX_GUARD))
  ) dut (
    .clk_48_i   (clk),
    .rst_i      (rst),
    .adr_i      (adr),
    .dat_i      (wdat),
    .we_i       (we),
    .stb_i      (stb),
    .cyc_i      (cyc),
    .sel_i      (sel),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_we_o     (m_we_o),
    .m_stb_o    (m_stb_o),
    .m_cyc_o    (m_cyc_o),
    .m_dat_i    (m_dat),
    .m_ack_i    (m_ack),
    .uart_irq_i (uirq),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // UART slave model: acks one cycle after a strobe, irq while RX bytes wait.
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  int         cyc_n = 0;
  int         n_uart_rd = 0;
  int         last_rd_cyc = 0;
  int         last_wr_cyc = 0;
  int         prev_wr_cyc = 0;
  int         sz;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack <= 1'b0;
      uirq  <= 1'b0;
      m_dat <= '0;
    end else begin
      cyc_n <= cyc_n + 1;
      sz = rxq.size();
      if (m_stb_o && m_cyc_o && !m_ack) begin
        m_ack <= 1'b1;
        if (m_we_o) begin
          txlog.push_back(m_dat_o[7:0]);
          prev_wr_cyc <= last_wr_cyc;
          last_wr_cyc <= cyc_n;
        end else begin
          n_uart_rd   <= n_uart_rd + 1;
          last_rd_cyc <= cyc_n;
          if (sz > 0) begin
            m_dat <= {24'hA5A5A5, rxq[0]};
            rxq.pop_front();
            sz = sz - 1;
          end else begin
            m_dat <= 32'hA5A5A5EE;
          end
        end
      end else begin
        m_ack <= 1'b0;
      end
      uirq <= (sz != 0);
    end
  end

  // Reference model: FIFO contents and overflow flag.
  logic [7:0] mq[$];
  logic       m_ovf;

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() < 16) mq.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] r;
    if (mq.size() > 0) begin
      r = 32'h100 | {24'h0, mq[0]};
      mq.pop_front();
    end else begin
      r = 32'h0;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_stat(input logic busy);
    logic [31:0] r;
    r = {25'b0, busy, m_ovf, 5'(mq.size())};
    m_ovf = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    bit got;
    @(negedge clk);
    adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (ack_o) got = 1'b1;
    end
    d = dat_o;
    stb = 1'b0; cyc = 1'b0;
    if (!got) check("read_ack_timeout", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input int budget,
                           output int waited);
    bit got;
    @(negedge clk);
    adr = a; wdat = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (ack_o) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) check("write_ack_timeout", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic inject(input logic [7:0] b);
    @(negedge clk);
    rxq.push_back(b);
    repeat (6) @(posedge clk);
    model_push(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxq.delete();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    logic [31:0] d;
    while (mq.size() > 0) begin
      cpu_read(DATA_ADR, d);
      check(tag, d, model_read());
    end
    cpu_read(DATA_ADR, d);
    check({tag, "_empty"}, d, 32'h0);
  endtask

  // Hard stop so a stuck DUT can never hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          w, w2, base, ntx;
    bit          found;
    rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; sel = 4'hF;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_madr", m_adr_o, UART_ADR);
    check("rst_mstb", {29'b0, m_stb_o, m_cyc_o, m_we_o}, 32'h0);
    cpu_read(STAT_ADR, d);
    check("rst_stat", d, model_stat(1'b0));

    // RX queueing.
    base = n_uart_rd;
    inject(8'h41); inject(8'h42); inject(8'h43);
    check("rxq_uart_reads", 32'(n_uart_rd - base), 32'd3);
    check("rxq_irq", 32'(irq_o), 32'd1);
    cpu_read(STAT_ADR, d);
    check("rxq_stat", d, model_stat(1'b0));
    drain_check("rxq_data");
    repeat (2) @(negedge clk);
    check("rxq_irq_clear", 32'(irq_o), 32'd0);

    // Overflow: 17 bytes with no reads.
    for (int i = 0; i < 17; i++) inject(8'(8'h60 + i));
    cpu_read(STAT_ADR, d);
    check("ovf_stat1", d, model_stat(1'b0));
    cpu_read(STAT_ADR, d);
    check("ovf_stat2", d, model_stat(1'b0));

    // Simultaneous push and pop while full: read ack edge meets M_RD ack edge.
    @(negedge clk);
    rxq.push_back(8'hC7);
    repeat (3) @(posedge clk);
    cpu_read(DATA_ADR, d);
    check("simul_data", d, model_read());
    model_push(8'hC7);
    repeat (4) @(negedge clk);
    cpu_read(STAT_ADR, d);
    check("simul_stat", d, model_stat(1'b0));
    drain_check("simul_order");

    // Randomized mix of RX bytes and CPU reads against the model.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        inject(8'($urandom));
      end else begin
        cpu_read(DATA_ADR, d);
        check("rand_data", d, model_read());
      end
      if (r % 10 == 9) begin
        cpu_read(STAT_ADR, d);
        check("rand_stat", d, model_stat(1'b0));
        check("rand_irq", 32'(irq_o), 32'(mq.size() != 0));
      end
    end
    drain_check("rand_drain");

    // RX priority: irq rises on the edge the TX byte is latched.
    ntx = txlog.size();
    @(negedge clk);
    rxq.push_back(8'h5A);
    adr = DATA_ADR; wdat = 32'hFFFF_FFA5; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ack_o) found = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("prio_wr_ack", 32'(found), 32'd1);
    model_push(8'h5A);
    repeat (4) @(negedge clk);
    check("prio_rd_first", 32'(last_rd_cyc < last_wr_cyc), 32'd1);
    check("prio_tx_count", 32'(txlog.size() - ntx), 32'd1);
    if (txlog.size() > ntx) check("prio_tx_byte", 32'(txlog[ntx]), 32'hA5);
    drain_check("prio_rx");

    // TX pacing.
    do_reset();
    ntx = txlog.size();
    cpu_write(DATA_ADR, 32'h55, 64, w);
    check("tx1_latency_ok", 32'(w <= 8), 32'd1);
    cpu_read(STAT_ADR, d);
    check("tx_busy_stat", d, model_stat(1'b1));
    cpu_write(DATA_ADR, 32'h56, 40000, w2);
    check("tx2_withheld", 32'(w2 >= TX_GUARD - 20 && w2 <= TX_GUARD + 10), 32'd1);
    check("tx_count", 32'(txlog.size() - ntx), 32'd2);
    if (txlog.size() >= ntx + 2) begin
      check("tx_byte1", 32'(txlog[ntx]), 32'h55);
      check("tx_byte2", 32'(txlog[ntx + 1]), 32'h56);
    end
    check("tx_spacing", 32'(last_wr_cyc - prev_wr_cyc >= TX_GUARD &&
                            last_wr_cyc - prev_wr_cyc <= TX_GUARD + 10), 32'd1);

    // Reset in the middle of a master write.
    do_reset();
    inject(8'h99);
    check("rstmid_irq_pre", 32'(irq_o), 32'd1);
    @(negedge clk);
    adr = DATA_ADR; wdat = 32'h77; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_stb_o && m_we_o && !m_ack) found = 1'b1;
    end
    check("rstmid_in_wr", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_mstb", {30'b0, m_stb_o, m_cyc_o}, 32'h0);
    check("rstmid_ack", 32'(ack_o), 32'd0);
    check("rstmid_irq", 32'(irq_o), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rxq.delete(); mq.delete(); m_ovf = 1'b0;
    cpu_read(STAT_ADR, d);
    check("rstmid_stat", d, model_stat(1'b0));
    cpu_read(DATA_ADR, d);
    check("rstmid_data", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
